// File: rtl/axis_stream_slave.sv
// axis_stream_slave: AXI-Stream receiver into a first-word-fall-through FIFO with packet counting.
// Define AXIS_SLV_LEN_CHECK_EN to build the sticky packet-length checker behind o_len_err.
module axis_stream_slave #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_tvalid,
    input  logic [DATA_W-1:0]        i_tdata,
    input  logic                     i_tlast,
    output logic                     o_tready,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_dout,
    output logic                     o_dout_last,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_pkt_done,
    output logic [7:0]               o_pkt_cnt,
    output logic                     o_len_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, RECV} state_t;
    logic [DATA_W:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_level;
    logic [7:0]      r_beat_cnt, r_pkt_cnt;
    logic            r_pkt_done;
    state_t          r_state;
    logic            w_push, w_pop, w_last_acc;
    logic [DATA_W:0] w_head;
    assign o_empty     = r_level == '0;
    assign o_full      = r_level == (AW+1)'(DEPTH);
    assign o_tready    = ~o_full & ~i_rst;
    assign w_push      = i_tvalid & o_tready;
    assign w_pop       = i_rd_en & ~o_empty;
    assign w_last_acc  = w_push & i_tlast;
    assign w_head      = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_dout      = w_head[DATA_W-1:0];
    assign o_dout_last = w_head[DATA_W];
    assign o_level     = r_level;
    assign o_pkt_done  = r_pkt_done;
    assign o_pkt_cnt   = r_pkt_cnt;
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_tlast, i_tdata};
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push != w_pop) r_level <= w_push ? r_level + (AW+1)'(1) : r_level - (AW+1)'(1);
        end
    end
    // beat_cnt is the index of the beat being accepted; it saturates on runaway packets
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= w_last_acc;
            if (w_push) begin
                r_state    <= i_tlast ? IDLE : RECV;
                r_beat_cnt <= i_tlast ? '0 : (r_state == IDLE) ? 8'd1 : r_beat_cnt + {7'd0, r_beat_cnt != 8'hFF};
            end
            if (w_last_acc) r_pkt_cnt <= r_pkt_cnt + 8'd1;
        end
    end
`ifdef AXIS_SLV_LEN_CHECK_EN
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
    logic r_len_err;
    // error when tlast arrives anywhere but the expected last index, or is missing there
    always_ff @(posedge i_clk) begin
        if (i_rst) r_len_err <= 1'b0;
        else if (w_push && (i_tlast != (r_beat_cnt == LAST_IDX))) r_len_err <= 1'b1;
    end
    assign o_len_err = r_len_err;
`else
    assign o_len_err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_stream_slave.sv
// tb_axis_stream_slave: randomized stream traffic checked by a queue-based reference model.
module tb_axis_stream_slave;
    localparam int DATA_W = 8, DEPTH = 8, PKT_LEN = 4;
    logic clk = 0, rst = 1, tvalid = 0, tlast = 0, rd_en = 0;
    logic [DATA_W-1:0] tdata = '0;
    logic tready, dout_last, empty, full, pkt_done, len_err;
    logic [DATA_W-1:0] dout;
    logic [$clog2(DEPTH):0] level;
    logic [7:0] pkt_cnt;
    int checks = 0, errors = 0;
    logic [DATA_W:0] m_q[$];
    logic [7:0] m_cnt = 0;
    logic m_done = 0, m_err = 0;
    int m_len = 0;

    axis_stream_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .i_clk(clk), .i_rst(rst), .i_tvalid(tvalid), .i_tdata(tdata), .i_tlast(tlast),
        .o_tready(tready), .i_rd_en(rd_en), .o_dout(dout), .o_dout_last(dout_last),
        .o_empty(empty), .o_full(full), .o_level(level), .o_pkt_done(pkt_done),
        .o_pkt_cnt(pkt_cnt), .o_len_err(len_err));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of {tlast,data} plus packet bookkeeping, compared each negedge
    always @(negedge clk) begin
        logic acc, pop;
        chk("tready", tready, !rst && m_q.size() < DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("full", full, m_q.size() == DEPTH);
        chk("level", level, m_q.size());
        chk("dout", dout, m_q.size() ? m_q[0][DATA_W-1:0] : 0);
        chk("dout_last", dout_last, m_q.size() ? m_q[0][DATA_W] : 0);
        chk("pkt_done", pkt_done, m_done);
        chk("pkt_cnt", pkt_cnt, m_cnt);
`ifdef AXIS_SLV_LEN_CHECK_EN
        chk("len_err", len_err, m_err);
`else
        chk("len_err", len_err, 0);
`endif
        if (rst) begin
            m_q.delete();
            m_cnt = 0; m_done = 0; m_err = 0; m_len = 0;
        end else begin
            acc = tvalid && m_q.size() < DEPTH;
            pop = rd_en && m_q.size() > 0;
            m_done = acc && tlast;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back({tlast, tdata});
                m_len++;
                if (tlast) begin
                    if (m_len != PKT_LEN) m_err = 1;
                    m_cnt++;
                    m_len = 0;
                end else if (m_len == PKT_LEN) m_err = 1;
            end
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic r);
        tvalid = v; tdata = d; tlast = l; rd_en = r;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, r);
    endtask

    task automatic reset_dut(input logic v);
        rst = 1;
        cyc(v, 8'hAA, 1, 1);
        rst = 0;
    endtask

    // Sends n beats, holding each until accepted; fix selects data 0x11,0x22,...
    task automatic send_pkt(input int n, input int rd_pct, input int gap_pct, input bit fix);
        int budget = 0;
        for (int i = 0; i < n;) begin
            logic acc;
            logic [DATA_W-1:0] d = fix ? DATA_W'(8'h11 * (i + 1)) : DATA_W'($urandom);
            tvalid = $urandom_range(99) >= gap_pct;
            tdata = d; tlast = (i == n - 1);
            rd_en = $urandom_range(99) < rd_pct;
            @(negedge clk);
            acc = tvalid & tready;
            @(posedge clk); #1;
            if (acc) i++;
            if (++budget > 2000) begin
                errors++;
                $display("FAIL send_pkt timeout: got %0d beats expected %0d", i, n);
                break;
            end
        end
        tvalid = 0; tlast = 0; rd_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(1, 8'h55, 0, 0);
        rst = 0;
        cyc(0, '0, 0, 0);
        send_pkt(4, 0, 0, 1);
        idle(2, 0);
        idle(5, 1);
        reset_dut(1);
        for (int i = 0; i < 10; i++) cyc(1, DATA_W'(8'hA0 + i), 0, 0);
        cyc(1, 8'hB0, 0, 1);
        cyc(1, 8'hB1, 1, 0);
        idle(12, 1);
        reset_dut(0);
        for (int i = 0; i < 3; i++) cyc(1, DATA_W'(8'hC0 + i), 0, 0);
        cyc(1, 8'hC3, 1, 1);
        idle(6, 1);
        reset_dut(0);
        send_pkt(4, 50, 20, 0);
        send_pkt(2, 50, 20, 0);
        idle(6, 1);
        reset_dut(0);
        send_pkt(5, 50, 0, 0);
        idle(6, 1);
        reset_dut(0);
        cyc(1, 8'hD0, 0, 0);
        cyc(1, 8'hD1, 0, 0);
        reset_dut(1);
        send_pkt(4, 30, 10, 0);
        idle(6, 1);
        for (int p = 0; p < 60; p++) begin
            if (p == 30) reset_dut($urandom_range(1));
            send_pkt($urandom_range(1, 6), $urandom_range(10, 90), $urandom_range(0, 40), 0);
        end
        idle(12, 1);
        for (int p = 0; p < 260; p++) send_pkt(1, 100, 0, 0);
        idle(4, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
